// File: rtl/cell_comm_link_stats_pkg.sv
// cell_comm_link_stats_pkg: shared link FSM encoding, readout selector codes and status-word layout.
package cell_comm_link_stats_pkg;
  typedef enum logic [1:0] {ST_DOWN = 2'd0, ST_QUALIFY = 2'd1, ST_UP = 2'd2} link_state_e;
  typedef enum logic [1:0] {RC_FAULT = 2'd0, RC_PASS = 2'd1, RC_DROP = 2'd2, RC_STATUS = 2'd3} read_sel_e;
  localparam int ST_STABLE_BIT = 0;
  localparam int ST_CHUP_BIT   = 1;
  localparam int ST_STATE_LSB  = 2;
endpackage

// File: rtl/cell_comm_link_monitor.sv
// cell_comm_link_monitor: one link's channel-up qualify FSM plus CRC fault/pass and drop counters.
// Ports: clk_i/rst_ni (sync, active-low), chan_up_i, crc_valid_i, crc_pass_i, clr_i (zero all counters);
//        fault_o/pass_o/drop_o counters, state_o FSM state, chan_up_o registered channel-up, stable_o (state is UP).
module cell_comm_link_monitor
  import cell_comm_link_stats_pkg::*;
#(
  parameter int COUNT_WIDTH   = 32,
  parameter bit SATURATE      = 1'b1,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   chan_up_i,
  input  logic                   crc_valid_i,
  input  logic                   crc_pass_i,
  input  logic                   clr_i,
  output logic [COUNT_WIDTH-1:0] fault_o,
  output logic [COUNT_WIDTH-1:0] pass_o,
  output logic [COUNT_WIDTH-1:0] drop_o,
  output link_state_e            state_o,
  output logic                   chan_up_o,
  output logic                   stable_o
);
  localparam int QW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  link_state_e state_q, state_d;
  logic [QW-1:0] q_q, q_d;
  logic [COUNT_WIDTH-1:0] fault_q, fault_d, pass_q, pass_d, drop_q, drop_d;
  logic up_q, drop_ev;
  function automatic logic [COUNT_WIDTH-1:0] bump(input logic [COUNT_WIDTH-1:0] c);
    return (SATURATE && &c) ? c : c + 1'b1;
  endfunction
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    drop_ev = 1'b0;
    unique case (state_q)
      ST_DOWN:    if (chan_up_i) begin state_d = ST_QUALIFY; q_d = '0; end
      ST_QUALIFY: if (!chan_up_i) state_d = ST_DOWN;
                  else if (q_q == QW'(STABLE_CYCLES - 1)) state_d = ST_UP;
                  else q_d = q_q + 1'b1;
      ST_UP:      if (!chan_up_i) begin state_d = ST_DOWN; drop_ev = 1'b1; end
      default:    state_d = ST_DOWN;
    endcase
    // clear takes priority over any increment on the same edge
    fault_d = clr_i ? '0 : (crc_valid_i && !crc_pass_i) ? bump(fault_q) : fault_q;
    pass_d  = clr_i ? '0 : (crc_valid_i && crc_pass_i) ? bump(pass_q) : pass_q;
    drop_d  = clr_i ? '0 : drop_ev ? bump(drop_q) : drop_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_DOWN;
      q_q     <= '0;
      fault_q <= '0;
      pass_q  <= '0;
      drop_q  <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      fault_q <= fault_d;
      pass_q  <= pass_d;
      drop_q  <= drop_d;
      up_q    <= chan_up_i;
    end
  end
  assign fault_o   = fault_q;
  assign pass_o    = pass_q;
  assign drop_o    = drop_q;
  assign state_o   = state_q;
  assign chan_up_o = up_q;
  assign stable_o  = state_q == ST_UP;
endmodule

// File: rtl/cell_comm_link_stats.sv
// cell_comm_link_stats: per-link Aurora health/CRC statistics with a registered CSR read mux.
// Ports: auUserClk, auUserResetN (sync, active-low); per-link channelUp, rxCRCvalid, rxCRCpass, clearMask;
//        clearStrobe; readSel/readCounter select -> readData (1-cycle); linkStable; crcFaultAny (registered).
module cell_comm_link_stats
  import cell_comm_link_stats_pkg::*;
#(
  parameter int NUM_LINKS     = 2,
  parameter int COUNT_WIDTH   = 32,
  parameter bit SATURATE      = 1'b1,
  parameter int STABLE_CYCLES = 1024,
  parameter int SEL_W         = NUM_LINKS > 1 ? $clog2(NUM_LINKS) : 1
) (
  input  logic                 auUserClk,
  input  logic                 auUserResetN,
  input  logic [NUM_LINKS-1:0] channelUp,
  input  logic [NUM_LINKS-1:0] rxCRCvalid,
  input  logic [NUM_LINKS-1:0] rxCRCpass,
  input  logic                 clearStrobe,
  input  logic [NUM_LINKS-1:0] clearMask,
  input  logic [SEL_W-1:0]     readSel,
  input  logic [1:0]           readCounter,
  output logic [31:0]          readData,
  output logic [NUM_LINKS-1:0] linkStable,
  output logic                 crcFaultAny
);
  logic [31:0] word [NUM_LINKS];
  logic [31:0] rd_d, rd_q;
  logic fany_q;
  for (genvar g = 0; g < NUM_LINKS; g++) begin : g_link
    logic [COUNT_WIDTH-1:0] f, p, d;
    link_state_e st;
    logic up;
    cell_comm_link_monitor #(
      .COUNT_WIDTH  (COUNT_WIDTH),
      .SATURATE     (SATURATE),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_mon (
      .clk_i      (auUserClk),
      .rst_ni     (auUserResetN),
      .chan_up_i  (channelUp[g]),
      .crc_valid_i(rxCRCvalid[g]),
      .crc_pass_i (rxCRCpass[g]),
      .clr_i      (clearStrobe && clearMask[g]),
      .fault_o    (f),
      .pass_o     (p),
      .drop_o     (d),
      .state_o    (st),
      .chan_up_o  (up),
      .stable_o   (linkStable[g])
    );
    assign word[g] = readCounter == RC_FAULT ? 32'(f) :
                     readCounter == RC_PASS  ? 32'(p) :
                     readCounter == RC_DROP  ? 32'(d) :
                     (32'(st) << ST_STATE_LSB) | (32'(up) << ST_CHUP_BIT) | (32'(linkStable[g]) << ST_STABLE_BIT);
  end
  // out-of-range selects match no link and read back as zero
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_LINKS; i++) if (readSel == SEL_W'(i)) rd_d = word[i];
  end
  always_ff @(posedge auUserClk) begin
    if (!auUserResetN) begin
      rd_q   <= '0;
      fany_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      fany_q <= |(rxCRCvalid & ~rxCRCpass);
    end
  end
  assign readData    = rd_q;
  assign crcFaultAny = fany_q;
endmodule

// File: tb/tb_cell_comm_link_stats.sv
// tb_cell_comm_link_stats: table, directed and random checks of cell_comm_link_stats against a run-length model.
module tb_cell_comm_link_stats;
  localparam int STB = 4;
  logic clk = 1'b0;
  logic rn = 1'b0, clr = 1'b0;
  logic [1:0] cu = '0, v = '0, p = '0, m = '0, sel = '0, rc = '0;
  logic [31:0] rd0, rd1, rd2;
  logic [1:0] ls0, ls1, ls2;
  logic fa0, fa1, fa2;
  int nvec = 0, nerr = 0;
  int run [2];
  longint flt [2], pas [2], drp [2];
  bit upq [2];
  bit m_fany;

  always #5 clk = ~clk;

  cell_comm_link_stats #(.NUM_LINKS(2), .COUNT_WIDTH(32), .SATURATE(1'b1), .STABLE_CYCLES(STB), .SEL_W(2)) dut (
    .auUserClk(clk), .auUserResetN(rn), .channelUp(cu), .rxCRCvalid(v), .rxCRCpass(p), .clearStrobe(clr),
    .clearMask(m), .readSel(sel), .readCounter(rc), .readData(rd0), .linkStable(ls0), .crcFaultAny(fa0));
  cell_comm_link_stats #(.NUM_LINKS(2), .COUNT_WIDTH(4), .SATURATE(1'b1), .STABLE_CYCLES(STB), .SEL_W(2)) dut_s4 (
    .auUserClk(clk), .auUserResetN(rn), .channelUp(cu), .rxCRCvalid(v), .rxCRCpass(p), .clearStrobe(clr),
    .clearMask(m), .readSel(sel), .readCounter(rc), .readData(rd1), .linkStable(ls1), .crcFaultAny(fa1));
  cell_comm_link_stats #(.NUM_LINKS(2), .COUNT_WIDTH(4), .SATURATE(1'b0), .STABLE_CYCLES(STB), .SEL_W(2)) dut_w4 (
    .auUserClk(clk), .auUserResetN(rn), .channelUp(cu), .rxCRCvalid(v), .rxCRCpass(p), .clearStrobe(clr),
    .clearMask(m), .readSel(sel), .readCounter(rc), .readData(rd2), .linkStable(ls2), .crcFaultAny(fa2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // a link is stable once it has seen more than STB consecutive high samples
  function automatic longint capv(input longint val, input int cw, input bit sat);
    longint mx = (longint'(1) << cw) - 1;
    return sat ? (val > mx ? mx : val) : (val & mx);
  endfunction

  function automatic longint mread(input int s, input int c, input int cw, input bit sat);
    longint st;
    if (s > 1) return 0;
    st = run[s] == 0 ? 0 : run[s] <= STB ? 1 : 2;
    case (c)
      0: return capv(flt[s], cw, sat);
      1: return capv(pas[s], cw, sat);
      2: return capv(drp[s], cw, sat);
      default: return (st << 2) | (longint'(upq[s]) << 1) | longint'(run[s] > STB);
    endcase
  endfunction

  task automatic step(input logic [1:0] icu, iv, ip, input logic iclr, input logic [1:0] im, isel, irc, input logic irn);
    longint e0, e1, e2;
    cu = icu; v = iv; p = ip; clr = iclr; m = im; sel = isel; rc = irc; rn = irn;
    e0 = irn ? mread(int'(isel), int'(irc), 32, 1'b1) : 0;
    e1 = irn ? mread(int'(isel), int'(irc), 4, 1'b1) : 0;
    e2 = irn ? mread(int'(isel), int'(irc), 4, 1'b0) : 0;
    if (!irn) begin
      m_fany = 1'b0;
      for (int l = 0; l < 2; l++) begin run[l] = 0; flt[l] = 0; pas[l] = 0; drp[l] = 0; upq[l] = 1'b0; end
    end else begin
      m_fany = |(iv & ~ip);
      for (int l = 0; l < 2; l++) begin
        if (!icu[l] && run[l] > STB) drp[l]++;
        if (iv[l] && !ip[l]) flt[l]++;
        if (iv[l] && ip[l]) pas[l]++;
        if (iclr && im[l]) begin flt[l] = 0; pas[l] = 0; drp[l] = 0; end
        run[l] = icu[l] ? (run[l] > STB ? run[l] : run[l] + 1) : 0;
        upq[l] = icu[l];
      end
    end
    @(posedge clk);
    #1;
    check("readData", 64'(rd0), 64'(e0));
    check("readData_sat4", 64'(rd1), 64'(e1));
    check("readData_wrap4", 64'(rd2), 64'(e2));
    check("linkStable", 64'(ls0), {62'd0, run[1] > STB, run[0] > STB});
    check("crcFaultAny", 64'(fa0), 64'(m_fany));
  endtask

  typedef struct {
    logic [1:0] cu, v, p;
    logic clr;
    logic [1:0] m, sel, rc;
    logic [31:0] rd;
    logic [1:0] ls;
    logic fa;
  } vec_t;
  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lows, nf, cnt;
    tbl[0]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd3, 32'h0, 2'b00, 1'b0};
    tbl[1]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd3, 32'h6, 2'b00, 1'b0};
    tbl[2]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd3, 32'h6, 2'b00, 1'b0};
    tbl[3]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd2, 32'h0, 2'b00, 1'b0};
    tbl[4]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd3, 32'h6, 2'b00, 1'b0};
    tbl[5]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd3, 32'h6, 2'b00, 1'b0};
    tbl[6]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd3, 32'h6, 2'b00, 1'b0};
    tbl[7]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd3, 32'h6, 2'b10, 1'b0};
    tbl[8]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd3, 32'hB, 2'b10, 1'b0};
    tbl[9]  = '{2'b10, 2'b11, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 2'b10, 1'b1};
    tbl[10] = '{2'b10, 2'b01, 2'b01, 1'b0, 2'b00, 2'd1, 2'd0, 32'h1, 2'b10, 1'b0};
    tbl[11] = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd1, 32'h1, 2'b10, 1'b0};
    tbl[12] = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd3, 2'd0, 32'h0, 2'b10, 1'b0};
    tbl[13] = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd2, 2'd3, 32'h0, 2'b10, 1'b0};
    for (int l = 0; l < 2; l++) begin run[l] = 0; flt[l] = 0; pas[l] = 0; drp[l] = 0; upq[l] = 1'b0; end
    m_fany = 1'b0;

    repeat (2) step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b0);
    check("reset_readData", 64'(rd0), 64'd0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].cu, tbl[i].v, tbl[i].p, tbl[i].clr, tbl[i].m, tbl[i].sel, tbl[i].rc, 1'b1);
      check($sformatf("tbl%0d_readData", i), 64'(rd0), 64'(tbl[i].rd));
      check($sformatf("tbl%0d_linkStable", i), 64'(ls0), 64'(tbl[i].ls));
      check($sformatf("tbl%0d_crcFaultAny", i), 64'(fa0), 64'(tbl[i].fa));
    end

    repeat (5) step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd3, 1'b1);
    check("link0_up", 64'(ls0[0]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step(2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd3, 1'b1);
      lows = 1;
      for (int j = 0; j < 20; j++) begin
        step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd3, 1'b1);
        if (ls0[0]) break;
        lows++;
      end
      check("drop_low_cycles", 64'(lows), 64'd5);
    end
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd2, 1'b1);
    check("drop_count", 64'(rd0), 64'd3);

    step(2'b11, 2'b00, 2'b00, 1'b1, 2'b11, 2'd0, 2'd0, 1'b1);
    nf = 0;
    for (int i = 0; i < 13; i++) begin
      if (i < 5) step(2'b11, 2'b01, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b1);
      else if (i < 12) step(2'b11, 2'b01, 2'b01, 1'b0, 2'b00, 2'd0, 2'd0, 1'b1);
      else step(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b1);
      nf += int'(fa0);
    end
    check("fault_pulses", 64'(nf), 64'd6);
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b1);
    check("link0_faults", 64'(rd0), 64'd6);
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd1, 1'b1);
    check("link0_passes", 64'(rd0), 64'd7);
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd0, 1'b1);
    check("link1_faults", 64'(rd0), 64'd1);

    repeat (14) step(2'b11, 2'b01, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b1);
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b1);
    check("faults20_w32", 64'(rd0), 64'd20);
    check("faults20_sat4", 64'(rd1), 64'h0F);
    check("faults20_wrap4", 64'(rd2), 64'h04);

    step(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 2'd0, 2'd0, 1'b1);
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b1);
    check("clear_link0_faults", 64'(rd0), 64'd0);
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd0, 1'b1);
    check("clear_keeps_link1", 64'(rd0), 64'd1);
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd3, 2'd0, 1'b1);
    check("sel3_zero", 64'(rd0), 64'd0);

    repeat (9) step(2'b11, 2'b01, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b1);
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b0);
    check("rst_readData", 64'(rd0), 64'd0);
    check("rst_linkStable", 64'(ls0), 64'd0);
    step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd3, 1'b1);
    check("rst_status_down", 64'(rd0), 64'd0);
    step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 1'b1);
    check("rst_faults_zero", 64'(rd0), 64'd0);
    step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd1, 2'd0, 1'b1);
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd2, 1'b1);
      cnt++;
      if (ls0[0]) break;
    end
    check("rst_requalify_edges", 64'(cnt), 64'd4);

    for (int i = 0; i < 1500; i++) begin
      logic [1:0] rcu;
      rcu = {$urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0};
      step(rcu, 2'($urandom), 2'($urandom), $urandom_range(0, 19) == 0, 2'($urandom),
           2'($urandom), 2'($urandom), $urandom_range(0, 199) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
